uart_cmd_assembler: RTL and testbench

//  Sits directly downstream of UART rx (rdy/rx_data/clr_rdy) and upstream of UART tx (trmt/tx_data/tx_done).

---
 rtl/uart_cmd_assembler.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// Assembles CMD_BYTES UART bytes into one command word and forwards response bytes to the UART tx.
// Optional inter-byte idle timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_assembler #(
  parameter int CMD_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [CMD_BYTES*8-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   send_resp,
  input  logic [7:0]             resp,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   resp_busy,
  output logic                   timeout_err
);

  localparam int W  = CMD_BYTES * 8;
  localparam int CW = $clog2(CMD_BYTES + 1);

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_ACK,
    RX_DROP
  } rx_st_e;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_st_e;

  rx_st_e         rx_st_q, rx_st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   asm_q, asm_d;
  logic [W-1:0]   cmd_q, cmd_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic           clr_q, clr_d;
  logic           take;

  tx_st_e         tx_st_q, tx_st_d;
  logic           trmt_q, trmt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           busy_q, busy_d;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]  idle_q, idle_d;
  logic           tmo_q, tmo_d;
`endif

  assign take = (rx_st_q == RX_WAIT) && rx_rdy && !cmd_rdy_q;

  always_comb begin
    rx_st_d   = rx_st_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    clr_d     = 1'b0;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    unique case (rx_st_q)
      RX_WAIT: begin
        if (take) begin
          clr_d   = 1'b1;
          rx_st_d = RX_ACK;
          if (cnt_q == CW'(CMD_BYTES - 1)) begin
            cmd_d     = {asm_q[W-9:0], rx_data};
            cmd_rdy_d = 1'b1;
            cnt_d     = '0;
            asm_d     = '0;
          end else begin
            asm_d = {asm_q[W-9:0], rx_data};
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_ACK:  rx_st_d = RX_DROP;
      RX_DROP: if (!rx_rdy) rx_st_d = RX_WAIT;
      default: rx_st_d = RX_WAIT;
    endcase
`ifdef UART_CMD_TIMEOUT_EN
    idle_d = idle_q;
    tmo_d  = 1'b0;
    if (take) begin
      idle_d = '0;
    end else if (rx_st_q == RX_WAIT && cnt_q != '0 && !cmd_rdy_q) begin
      // Stalled partial command: throw it away
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        idle_d = '0;
        tmo_d  = 1'b1;
        cnt_d  = '0;
        asm_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d = resp;
          trmt_d    = 1'b1;
          busy_d    = 1'b1;
          tx_st_d   = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          busy_d  = 1'b0;
          tx_st_d = TX_IDLE;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q   <= RX_WAIT;
      cnt_q     <= '0;
      asm_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      clr_q     <= 1'b0;
      tx_st_q   <= TX_IDLE;
      trmt_q    <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      clr_q     <= clr_d;
      tx_st_q   <= tx_st_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign clr_rx_rdy = clr_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign trmt       = trmt_q;
  assign tx_data    = tx_data_q;
  assign resp_busy  = busy_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: command assembly, back-pressure, tx path, reset.
// Timeout scenario runs when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_busy;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_clr  = 0;
  int n_trmt = 0;
  int base;
  int seen;

  uart_cmd_assembler #(
    .CMD_BYTES      (3),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && clr_rx_rdy) n_clr++;
    if (rst_n && trmt) n_trmt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // UART rx model: hold rdy until acknowledged, then drop it
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    repeat (3) @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) begin
        got = 1'b1;
        break;
      end
    end
    rx_rdy = 1'b0;
    chk("byte_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic clear_cmd;
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    resp        = 8'h00;
    tx_done     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {8'd0, cmd}, 32'h0);
    chk("rst_flags", {26'd0, clr_rx_rdy, cmd_rdy, trmt, resp_busy,
        timeout_err, 1'b0}, 32'h0);
    chk("rst_txdata", {24'd0, tx_data}, 32'h0);
    rst_n = 1'b1;

    base = n_clr;
    send_byte(8'hA5);
    send_byte(8'h12);
    @(negedge clk);
    chk("partial_hidden", {7'd0, cmd_rdy, cmd}, 32'h0);
    send_byte(8'h3C);
    chk("cmd_rdy_with_ack", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    chk("cmd_a5123c", {8'd0, cmd}, 32'h00A5123C);
    chk("three_acks", n_clr - base, 32'd3);

    clear_cmd();
    chk("clr_drops_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("cmd_retained", {8'd0, cmd}, 32'h00A5123C);
    clear_cmd();
    chk("clr_idle_noeffect", {7'd0, cmd_rdy, cmd}, 32'h00A5123C);

    base = n_clr;
    @(negedge clk);
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    repeat (10) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    chk("hold_one_ack", n_clr - base, 32'd1);
    send_byte(8'h66);
    send_byte(8'h99);
    @(negedge clk);
    chk("cmd_556699", {7'd0, cmd_rdy, cmd}, 32'h01556699);

    base = n_clr;
    @(negedge clk);
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    repeat (5) @(negedge clk);
    chk("backpressure_noack", n_clr - base, 32'd0);
    chk("backpressure_cmd", {8'd0, cmd}, 32'h00556699);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clear_wins", {30'd0, cmd_rdy, clr_rx_rdy}, 32'd0);
    @(negedge clk);
    chk("pending_captured", {31'd0, clr_rx_rdy}, 32'd1);
    rx_rdy = 1'b0;
    send_byte(8'h88);
    send_byte(8'h99);
    @(negedge clk);
    chk("cmd_778899", {7'd0, cmd_rdy, cmd}, 32'h01778899);
    clear_cmd();

    base = n_trmt;
    resp      = 8'hC3;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk("trmt_pulse", {31'd0, trmt}, 32'd1);
    chk("txdata_c3", {23'd0, resp_busy, tx_data}, 32'h1C3);
    @(negedge clk);
    chk("trmt_single", {31'd0, trmt}, 32'd0);
    resp      = 8'h5A;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk("busy_drop", {22'd0, trmt, resp_busy, tx_data}, 32'h1C3);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("done_idle", {23'd0, resp_busy, tx_data}, 32'h0C3);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk("second_resp", {22'd0, trmt, resp_busy, tx_data}, 32'h35A);
    @(negedge clk);
    chk("trmt_count", n_trmt - base, 32'd2);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;

    send_byte(8'h11);
    send_byte(8'h22);
    resp      = 8'hEE;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk("busy_before_rst", {31'd0, resp_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd", {8'd0, cmd}, 32'h0);
    chk("mid_rst_flags", {23'd0, clr_rx_rdy, cmd_rdy, trmt, resp_busy,
        timeout_err, tx_data[2:0]}, 32'h0);
    chk("mid_rst_txdata", {24'd0, tx_data}, 32'h0);
    rst_n = 1'b1;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    @(negedge clk);
    chk("cmd_abcdef", {7'd0, cmd_rdy, cmd}, 32'h01ABCDEF);
    chk("no_timeout_yet", {31'd0, timeout_err}, 32'd0);
    clear_cmd();

`ifdef UART_CMD_TIMEOUT_EN
    send_byte(8'hFF);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err) seen++;
    end
    chk("timeout_pulse", seen, 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    chk("cmd_010203", {7'd0, cmd_rdy, cmd}, 32'h01010203);
`else
    send_byte(8'hFF);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err) seen++;
    end
    chk("timeout_tied0", seen, 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    chk("partial_waits", {7'd0, cmd_rdy, cmd}, 32'h01FF0102);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
